spi_cmd_controller: RTL

Command sequencer between the serial-to-parallel SPI receiver and the chip's configuration register bank. It consumes completed 8-bit bytes (already moved into the internal clock domain), decodes a command byte (read/write + address), and issues register writes or reads. Burst transfers auto-increment the address. An idle-gap timeout ends each frame.

---
 rtl/psec5_spi_pkg.sv | 16 +
 rtl/spi_idle_timer.sv | 25 ++
 rtl/spi_cmd_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/psec5_spi_pkg.sv
// Shared types and constants for the SPI command sequencer.
package psec5_spi_pkg;

  localparam int CMD_RW_BIT = 7;
  localparam int ADDR_W     = 7;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    RD_REQ,
    RD_CAP,
    RD_WAIT,
    DISCARD
  } state_e;

endpackage

// File: rtl/spi_idle_timer.sv
// Idle-gap counter: expires once TIMEOUT consecutive enabled cycles pass without clear.
module spi_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic iclk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // The counter would step to TIMEOUT on this edge; a same-cycle clear wins.
  assign expired = enable && !clear && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn)                          cnt_q <= '0;
    else if (!enable || clear || expired) cnt_q <= '0;
    else                                cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/spi_cmd_controller.sv
// Decodes SPI command bytes into register-bank read/write strobes with burst auto-increment.
module spi_cmd_controller
  import psec5_spi_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic              iclk,
  input  logic              rstn,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              err_clr,
  input  logic [7:0]        reg_rdata,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam logic [ADDR_W:0] NREGS = NUM_REGS[ADDR_W:0];

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   addr_inc;
  logic              cmd_bad, addr_ovf, tmo;

  assign addr_inc = {1'b0, addr_q} + 1'b1;
  assign addr_ovf = (addr_inc == NREGS);
  assign cmd_bad  = ({1'b0, byte_in[ADDR_W-1:0]} >= NREGS);

  spi_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .iclk    (iclk),
    .rstn    (rstn),
    .clear   (byte_valid),
    .enable  (state_q != IDLE),
    .expired (tmo)
  );

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      tx_byte    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      tx_valid   <= 1'b0;
      frame_done <= 1'b0;
      // Later err <= 1 assignments override this, so a set beats a clear.
      if (err_clr) err <= 1'b0;
      if (tmo) begin
        state_q    <= IDLE;
        busy       <= 1'b0;
        frame_done <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (byte_valid) begin
            addr_q <= byte_in[ADDR_W-1:0];
            busy   <= 1'b1;
            if (cmd_bad) begin
              err     <= 1'b1;
              state_q <= DISCARD;
            end else if (byte_in[CMD_RW_BIT]) begin
              reg_rd_en <= 1'b1;
              reg_addr  <= byte_in[ADDR_W-1:0];
              state_q   <= RD_REQ;
            end else begin
              state_q <= WR_DATA;
            end
          end
          WR_DATA: if (byte_valid) begin
            reg_wr_en <= 1'b1;
            reg_addr  <= addr_q;
            reg_wdata <= byte_in;
            addr_q    <= addr_inc[ADDR_W-1:0];
            if (addr_ovf) begin
              err     <= 1'b1;
              state_q <= DISCARD;
            end
          end
          RD_REQ: state_q <= RD_CAP;
          RD_CAP: begin
            tx_byte  <= reg_rdata;
            tx_valid <= 1'b1;
            state_q  <= RD_WAIT;
          end
          RD_WAIT: if (byte_valid) begin
            addr_q <= addr_inc[ADDR_W-1:0];
            if (addr_ovf) begin
              err     <= 1'b1;
              state_q <= DISCARD;
            end else begin
              reg_rd_en <= 1'b1;
              reg_addr  <= addr_inc[ADDR_W-1:0];
              state_q   <= RD_REQ;
            end
          end
          DISCARD: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
